// File: rtl/pcpi_arb_pkg.sv
// pcpi_arb_pkg: shared types, data width and grant-id sizing for the PCPI coprocessor arbiter.
package pcpi_arb_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {IDLE, BUSY, RESP, COOL} state_t;

    function automatic int gid_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pcpi_copro_arb_if.sv
// pcpi_copro_arb_if: core-side PCPI port plus the broadcast coprocessor bus; slave = arbiter view.
interface pcpi_copro_arb_if #(
    parameter int NUM_COPRO = 2
);
    import pcpi_arb_pkg::*;
    localparam int GW = gid_w(NUM_COPRO);

    logic                      pcpi_valid;
    logic [XLEN-1:0]           pcpi_insn;
    logic [XLEN-1:0]           pcpi_rs1;
    logic [XLEN-1:0]           pcpi_rs2;
    logic                      pcpi_wr;
    logic [XLEN-1:0]           pcpi_rd;
    logic                      pcpi_wait;
    logic                      pcpi_ready;
    logic [NUM_COPRO-1:0]      cp_valid;
    logic [XLEN-1:0]           cp_insn;
    logic [XLEN-1:0]           cp_rs1;
    logic [XLEN-1:0]           cp_rs2;
    logic [NUM_COPRO-1:0]      cp_wr;
    logic [NUM_COPRO*XLEN-1:0] cp_rd;
    logic [NUM_COPRO-1:0]      cp_wait;
    logic [NUM_COPRO-1:0]      cp_ready;
    logic [GW-1:0]             grant_id;
    logic                      multi_ready;
    logic                      timeout;

    modport slave (
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, cp_wr, cp_rd, cp_wait, cp_ready,
        output pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, cp_valid, cp_insn, cp_rs1, cp_rs2,
               grant_id, multi_ready, timeout
    );

    modport master (
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, cp_wr, cp_rd, cp_wait, cp_ready,
        input  pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, cp_valid, cp_insn, cp_rs1, cp_rs2,
               grant_id, multi_ready, timeout
    );
endinterface

// File: rtl/pcpi_arb_prio_enc.sv
// pcpi_arb_prio_enc: lowest-index winner of the cp_ready vector plus any/multiple flags.
module pcpi_arb_prio_enc
    import pcpi_arb_pkg::*;
#(
    parameter int NUM_COPRO = 2
) (
    input  logic [NUM_COPRO-1:0]           ready_i,
    output logic [gid_w(NUM_COPRO)-1:0]    id_o,
    output logic                           any_o,
    output logic                           multi_o
);
    localparam int W = gid_w(NUM_COPRO);

    always_comb begin
        id_o = '0;
        for (int i = NUM_COPRO - 1; i >= 0; i--)
            if (ready_i[i]) id_o = i[W-1:0];
    end

    assign any_o   = |ready_i;
    assign multi_o = $countones(ready_i) > 1;
endmodule

// File: rtl/pcpi_copro_arb.sv
// pcpi_copro_arb: broadcasts one PicoRV32 PCPI request to NUM_COPRO coprocessors and returns the first claim.
// Build option: define PCPI_ARB_TIMEOUT_EN to abort requests that no coprocessor claims.
module pcpi_copro_arb
    import pcpi_arb_pkg::*;
#(
    parameter int NUM_COPRO = 2,
    parameter int TIMEOUT   = 16
) (
    input logic             clk,
    input logic             reset,
    pcpi_copro_arb_if.slave bus
);
    localparam int GW = gid_w(NUM_COPRO);

    if (NUM_COPRO < 2 || TIMEOUT < 2) begin : g_cfg_err
        $error("pcpi_copro_arb: NUM_COPRO and TIMEOUT must both be at least 2");
    end

    state_t          state_q, state_d;
    logic [XLEN-1:0] insn_q, rs1_q, rs2_q, rd_q;
    logic [GW-1:0]   gid_q, win_id;
    logic            wr_q, ready_q, multi_q, tmo_q;
    logic            any_rdy, multi, busy, idle_go, abort, grant, expire;

    pcpi_arb_prio_enc #(.NUM_COPRO(NUM_COPRO)) u_enc (
        .ready_i (bus.cp_ready),
        .id_o    (win_id),
        .any_o   (any_rdy),
        .multi_o (multi)
    );

    assign busy    = state_q == BUSY;
    assign idle_go = state_q == IDLE && bus.pcpi_valid;
    assign abort   = busy && !bus.pcpi_valid;
    assign grant   = busy && bus.pcpi_valid && any_rdy;

`ifdef PCPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q;
    logic          stall;

    // A cycle with neither wait nor ready is the only kind that ages the request.
    assign stall  = busy && !any_rdy && !(|bus.cp_wait);
    assign expire = stall && bus.pcpi_valid && cnt_q == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else if (idle_go) cnt_q <= '0;
        else if (stall) cnt_q <= cnt_q + 1'b1;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.pcpi_valid ? BUSY : IDLE;
            BUSY:    state_d = (abort || expire) ? IDLE : grant ? RESP : BUSY;
            RESP:    state_d = COOL;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            insn_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            gid_q   <= '0;
            wr_q    <= 1'b0;
            ready_q <= 1'b0;
            multi_q <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= grant;
            wr_q    <= grant && bus.cp_wr[win_id];
            multi_q <= grant && multi;
            tmo_q   <= expire;
            if (idle_go) begin
                insn_q <= bus.pcpi_insn;
                rs1_q  <= bus.pcpi_rs1;
                rs2_q  <= bus.pcpi_rs2;
            end
            if (grant) begin
                rd_q  <= bus.cp_rd[XLEN*win_id +: XLEN];
                gid_q <= win_id;
            end
        end

    assign bus.pcpi_wr     = wr_q;
    assign bus.pcpi_rd     = rd_q;
    assign bus.pcpi_ready  = ready_q;
    assign bus.pcpi_wait   = busy && |bus.cp_wait;
    assign bus.cp_valid    = {NUM_COPRO{busy}};
    assign bus.cp_insn     = insn_q;
    assign bus.cp_rs1      = rs1_q;
    assign bus.cp_rs2      = rs2_q;
    assign bus.grant_id    = gid_q;
    assign bus.multi_ready = multi_q;
    assign bus.timeout     = tmo_q;
endmodule

// File: doc/pcpi_copro_arb.md
# pcpi_copro_arb

Controller that sits between the PicoRV32 core's single PCPI port and several PCPI coprocessors, such as the divider and the multiplier. It captures each core request, broadcasts it to all coprocessors and picks the first one that claims it. It then returns that unit's result to the core as a registered one-cycle response, and aborts with a timeout when no unit claims the instruction.

## Interface

Parameters:
- NUM_COPRO, default 2: number of coprocessor slots, minimum 2.
- TIMEOUT, default 16: cycles in BUSY with no cp_wait and no cp_ready before the request is aborted.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: reset is asynchronous and active-high.
- pcpi_valid, input, 1: core request.
- pcpi_insn, input, 32: core instruction word.
- pcpi_rs1, input, 32: core operand 1.
- pcpi_rs2, input, 32: core operand 2.
- pcpi_wr, output, 1: result valid for write-back.
- pcpi_rd, output, 32: result.
- pcpi_wait, output, 1: some coprocessor is busy on the request.
- pcpi_ready, output, 1: one-cycle completion pulse.
- cp_valid, output, NUM_COPRO: per-slot request; all bits equal.
- cp_insn, output, 32: latched instruction word, broadcast.
- cp_rs1, output, 32: latched operand 1, broadcast.
- cp_rs2, output, 32: latched operand 2, broadcast.
- cp_wr, input, NUM_COPRO: per-slot write flag.
- cp_rd, input, NUM_COPRO*32: per-slot result; slot i at [32*i +: 32].
- cp_wait, input, NUM_COPRO: per-slot wait.
- cp_ready, input, NUM_COPRO: per-slot ready.
- grant_id, output, max(1,$clog2(NUM_COPRO)): winning slot; valid while pcpi_ready=1.
- multi_ready, output, 1: pulse when more than one cp_ready bit is set in the same cycle.
- timeout, output, 1: pulse when a request is aborted on timeout.

## Operation

The controller is a four-state FSM:

- **IDLE**
  - All cp_valid bits are 0.
  - When pcpi_valid=1: latch pcpi_insn, pcpi_rs1 and pcpi_rs2 into cp_insn, cp_rs1 and cp_rs2; clear the timeout counter; go to BUSY.
- **BUSY**
  - cp_valid = all ones; pcpi_wait = |cp_wait.
  - When any cp_ready=1: the lowest set index wins.
    - Register cp_rd[winner] into pcpi_rd, cp_wr[winner] into pcpi_wr, and the winner's index into grant_id.
    - If popcount(cp_ready) > 1, pulse multi_ready.
    - Go to RESP.
  - When pcpi_valid=0 (core abort): go to IDLE; pcpi_rd is unchanged; no response is given.
  - When |cp_wait=1: the timeout counter holds its value.
  - When no cp_wait and no cp_ready: the counter increments.
    - When the counter reaches TIMEOUT-1 and still no cp_wait and no cp_ready: pulse timeout and go to IDLE with no pcpi_ready.
    - The core's own PCPI timeout then raises an illegal-instruction trap.
- **RESP**
  - pcpi_ready=1 for exactly one cycle; cp_valid=0; pcpi_wait=0.
  - Go to COOL.
- **COOL**
  - One dead cycle; cp_valid=0; pcpi_valid is ignored.
  - Go to IDLE.
  - This guarantees that a pcpi_valid still high from the old request is never re-dispatched.

Signal rules:
- cp_ready and cp_wait are ignored outside BUSY.
- pcpi_wr, pcpi_ready, multi_ready and timeout are 0 in every state except their defined pulse cycle.
- pcpi_rd holds its last value.

## Timing

- **Reset values:** state=IDLE; pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready = 0; cp_valid, cp_insn, cp_rs1, cp_rs2 = 0; grant_id, multi_ready, timeout, counter = 0.
- **Request capture:** pcpi_valid sampled at edge N; cp_valid=1 from cycle N+1.
- **Completion:** cp_ready sampled at edge M; pcpi_ready and pcpi_rd valid in cycle M+1.
- **Minimum latency:** valid to ready is 2 cycles, when a coprocessor answers in its first BUSY cycle. Minimum request spacing is 4 cycles.
- **Abort precedence:** cp_ready and pcpi_valid=0 in the same BUSY cycle → the abort wins; no response.
- **Timeout precedence:** cp_ready on the timeout cycle → the response wins; no timeout.
- **Reset mid-transaction:** asynchronous return to IDLE; all outputs cleared immediately.
- **Output register:** pcpi_wait is combinational from cp_wait, gated by a registered BUSY flag. All other outputs are registered.

## Configuration

- **PCPI_ARB_TIMEOUT_EN defined:** timeout counter and abort path as above.
- **PCPI_ARB_TIMEOUT_EN undefined:**
  - No counter logic; the timeout output is tied to 0.
  - BUSY exits only on cp_ready or core abort.
  - TIMEOUT is unused.

## Structure

- **Package pcpi_arb_pkg:**
  - state enum: IDLE, BUSY, RESP, COOL.
  - localparam XLEN=32.
  - Helper function for the grant_id width.
- **Sub-module pcpi_arb_prio_enc:** parameterised by NUM_COPRO. Takes the cp_ready vector and produces the lowest-index id, an any flag and a multiple flag.

## Test plan

- **Single divide:** slot 0 asserts cp_wait for 5 cycles, then cp_ready with cp_wr=1 and rd=0x0000_0007 for rs1=35, rs2=5. Expect pcpi_ready=1, pcpi_wr=1, pcpi_rd=7 and grant_id=0 one cycle later, then cp_valid=0.
- **Simultaneous ready:** slots 0 and 1 assert ready in the same cycle with rd 0xAAAA_AAAA and 0x5555_5555. Expect pcpi_rd=0xAAAA_AAAA, grant_id=0 and multi_ready pulsed once.
- **Unclaimed instruction (macro defined, TIMEOUT=16):** no wait or ready. Expect timeout pulsed 16 cycles after entering BUSY, no pcpi_ready, then IDLE. With the macro undefined, BUSY is held for at least 100 cycles.
- **Core abort:** pcpi_valid drops in BUSY cycle 3 while slot 1 asserts ready in the same cycle. Expect no pcpi_ready and cp_valid=0 next cycle.
- **Back-to-back requests:** pcpi_valid held high through RESP. Expect no re-dispatch during COOL and a new capture in the following IDLE with new operands.
- **Reset mid-transaction:** assert reset in BUSY. Expect all outputs 0 asynchronously; after release, the first request completes normally.
